vertex_xform_seq: RTL and testbench

//  Initiator for the 4x4 matrix-vector engine (mat_vec_mult4D, mult_vec=1).

---
 rtl/vertex_xform_seq_pkg.sv | 15 +
 rtl/vertex_xform_seq.sv | 134 +++++++++++++
 tb/tb_vertex_xform_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/vertex_xform_seq_pkg.sv
// Shared constants and state encoding for the vertex transform initiator.
package vertex_xform_seq_pkg;

    localparam logic [31:0] FLOAT_ONE    = 32'h3F800000;
    localparam int          VERTEX_WORDS = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_START = 3'd2,
        S_BUSY  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

endpackage

// File: rtl/vertex_xform_seq.sv
// Fetches x,y,z per vertex, appends w=1.0, runs the 4x4 engine and presents the result.
// About 44 cycles per vertex; a stalled output holds the result and blocks the next fetch.
module vertex_xform_seq
    import vertex_xform_seq_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_start,
    input  logic [ADDR_WIDTH-1:0]  cmd_base,
    input  logic [COUNT_WIDTH-1:0] cmd_count,
    output logic                   busy,
    output logic                   job_done,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [31:0]            mem_rdata,
    output logic                   mv_start,
    output logic                   mv_mult_vec,
    output logic [31:0]            mv_v11,
    output logic [31:0]            mv_v21,
    output logic [31:0]            mv_v31,
    output logic [31:0]            mv_v41,
    input  logic                   mv_done,
    input  logic [31:0]            mv_o11,
    input  logic [31:0]            mv_o21,
    input  logic [31:0]            mv_o31,
    input  logic [31:0]            mv_o41,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_x,
    output logic [31:0]            out_y,
    output logic [31:0]            out_z,
    output logic [31:0]            out_w
);

    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_ptr;
    logic [COUNT_WIDTH-1:0] r_remaining;
    logic [1:0]             r_wcnt;
    logic [ADDR_WIDTH-1:0]  w_next_addr;

    assign w_next_addr = r_ptr + ADDR_WIDTH'(r_wcnt) + ADDR_WIDTH'(1);

    // Start is qualified by the live idle flag so it can never fire into a busy engine.
    assign mv_start    = (r_state == S_START) && mv_done;
    assign mv_mult_vec = 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_wcnt      <= '0;
            busy        <= 1'b0;
            job_done    <= 1'b0;
            mem_addr    <= '0;
            mv_v11      <= '0;
            mv_v21      <= '0;
            mv_v31      <= '0;
            mv_v41      <= '0;
            out_valid   <= 1'b0;
            out_x       <= '0;
            out_y       <= '0;
            out_z       <= '0;
            out_w       <= '0;
        end else begin
            job_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_start) begin
                        if (cmd_count == '0) begin
                            job_done <= 1'b1;
                        end else begin
                            busy        <= 1'b1;
                            r_ptr       <= cmd_base;
                            mem_addr    <= cmd_base;
                            r_remaining <= cmd_count;
                            r_wcnt      <= '0;
                            r_state     <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    r_wcnt <= r_wcnt + 2'd1;
                    if (r_wcnt < 2'd2)
                        mem_addr <= w_next_addr;
                    // Read data lags the address by one cycle, so word k lands on cycle k+1.
                    case (r_wcnt)
                        2'd0: mv_v41 <= FLOAT_ONE;
                        2'd1: mv_v11 <= mem_rdata;
                        2'd2: mv_v21 <= mem_rdata;
                        2'd3: begin
                            mv_v31  <= mem_rdata;
                            r_ptr   <= r_ptr + ADDR_WIDTH'(VERTEX_WORDS);
                            r_state <= S_START;
                        end
                    endcase
                end
                S_START: begin
                    if (mv_done)
                        r_state <= S_BUSY;
                end
                S_BUSY: begin
                    if (mv_done) begin
                        out_x     <= mv_o11;
                        out_y     <= mv_o21;
                        out_z     <= mv_o31;
                        out_w     <= mv_o41;
                        out_valid <= 1'b1;
                        r_state   <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (r_remaining == COUNT_WIDTH'(1)) begin
                            job_done <= 1'b1;
                            busy     <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_remaining <= r_remaining - COUNT_WIDTH'(1);
                            mem_addr    <= r_ptr;
                            r_wcnt      <= '0;
                            r_state     <= S_FETCH;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vertex_xform_seq.sv
// Drives random vertex jobs through vertex_xform_seq with a diagonal-matrix engine stub
// and a 1-cycle RAM, comparing every output vertex against a queue built from RAM contents.
module tb_vertex_xform_seq;
    import vertex_xform_seq_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_start;
    logic [15:0] cmd_base;
    logic [15:0] cmd_count;
    logic        busy, job_done;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mv_start, mv_mult_vec;
    logic [31:0] mv_v11, mv_v21, mv_v31, mv_v41;
    logic        mv_done;
    logic [31:0] mv_o11, mv_o21, mv_o31, mv_o41;
    logic        out_valid, out_ready;
    logic [31:0] out_x, out_y, out_z, out_w;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] ram [65536];
    logic [127:0] exp_q [$];
    int          eng_e [4];
    logic [5:0]  eng_cnt;

    always #5 clock = ~clock;

    vertex_xform_seq #(.ADDR_WIDTH(16), .COUNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset),
        .cmd_start(cmd_start), .cmd_base(cmd_base), .cmd_count(cmd_count),
        .busy(busy), .job_done(job_done),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mv_start(mv_start), .mv_mult_vec(mv_mult_vec),
        .mv_v11(mv_v11), .mv_v21(mv_v21), .mv_v31(mv_v31), .mv_v41(mv_v41),
        .mv_done(mv_done),
        .mv_o11(mv_o11), .mv_o21(mv_o21), .mv_o31(mv_o31), .mv_o41(mv_o41),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_w(out_w)
    );

    // Multiply a normal float by 2^e by adjusting its exponent field.
    function automatic logic [31:0] scale(input logic [31:0] f, input int e);
        return {f[31], f[30:23] + 8'(e), f[22:0]};
    endfunction

    function automatic logic [31:0] rand_float();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction

    always @(posedge clock) mem_rdata <= ram[mem_addr];

    // Engine stand-in: diagonal matrix diag(2^e0..2^e3), fixed latency, operands read at completion.
    always @(posedge clock) begin
        if (reset) begin
            mv_done <= 1'b1;
            eng_cnt <= '0;
            mv_o11 <= '0; mv_o21 <= '0; mv_o31 <= '0; mv_o41 <= '0;
        end else if (mv_start && mv_done) begin
            mv_done <= 1'b0;
            eng_cnt <= 6'd36;
        end else if (!mv_done) begin
            if (eng_cnt == 6'd0) begin
                mv_o11  <= scale(mv_v11, eng_e[0]);
                mv_o21  <= scale(mv_v21, eng_e[1]);
                mv_o31  <= scale(mv_v31, eng_e[2]);
                mv_o41  <= scale(mv_v41, eng_e[3]);
                mv_done <= 1'b1;
            end else begin
                eng_cnt <= eng_cnt - 6'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // rmode: 0 ready always high, 1 random ready, 2 stall first result 20 cycles.
    task automatic run_job(input logic [15:0] base, input logic [15:0] cnt,
                           input int rmode, input bit poke);
        int starts, jd, got, stall, st_at, cyc;
        logic [15:0] a;
        exp_q.delete();
        for (int i = 0; i < int'(cnt); i++) begin
            a = base + 16'(3 * i);
            exp_q.push_back({scale(ram[a], eng_e[0]), scale(ram[a + 16'd1], eng_e[1]),
                             scale(ram[a + 16'd2], eng_e[2]), scale(FLOAT_ONE, eng_e[3])});
        end
        cmd_base  = base;
        cmd_count = cnt;
        cmd_start = 1'b1;
        @(negedge clock);
        cmd_start = 1'b0;
        chk("busy_after_start", 128'(busy), 128'(1));
        chk("first_addr", 128'(mem_addr), 128'(base));
        starts = 0; jd = 0; got = 0; stall = 0; st_at = 0;
        for (cyc = 0; cyc < 200 * int'(cnt) + 100 && jd == 0; cyc++) begin
            @(negedge clock);
            cmd_start = 1'b0;
            if (poke && cyc == 30) begin
                cmd_start = 1'b1;
                cmd_base  = 16'h1234;
                cmd_count = 16'd7;
            end
            if (mv_start) starts++;
            if (job_done) begin
                jd++;
                chk("done_after_last", 128'(got), 128'(cnt));
                chk("busy_at_done", 128'(busy), 128'(0));
            end
            if (rmode == 2 && out_valid && stall < 20) begin
                out_ready = 1'b0;
                stall++;
                if (stall == 1) st_at = starts;
                if (stall == 20) begin
                    chk("stall_hold", {out_x, out_y, out_z, out_w}, exp_q[0]);
                    chk("stall_valid", 128'(out_valid), 128'(1));
                    chk("stall_no_start", 128'(starts), 128'(st_at));
                end
            end else begin
                out_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_output", 128'(1), 128'(0));
                end else begin
                    chk("vertex_out", {out_x, out_y, out_z, out_w}, exp_q.pop_front());
                    got++;
                end
            end
        end
        chk("job_done_count", 128'(jd), 128'(1));
        chk("engine_starts", 128'(starts), 128'(cnt));
        chk("outputs", 128'(got), 128'(cnt));
        @(negedge clock);
        chk("done_one_cycle", 128'(job_done), 128'(0));
        cmd_start = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        logic [15:0] saved;
        bit seen;
        reset = 1'b1; cmd_start = 1'b0; cmd_base = '0; cmd_count = '0; out_ready = 1'b1;
        eng_e = '{0, 0, 0, 0};
        for (int i = 0; i < 65536; i++) ram[i] = rand_float();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_job_done", 128'(job_done), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_mem_addr", 128'(mem_addr), 128'(0));
        chk("rst_mv_start", 128'(mv_start), 128'(0));
        chk("rst_mv_v", {mv_v11, mv_v21, mv_v31, mv_v41}, 128'(0));
        chk("rst_out", {out_x, out_y, out_z, out_w}, 128'(0));
        chk("mult_vec", 128'(mv_mult_vec), 128'(1));

        // Identity matrix, known vertex (1,2,3).
        ram[16'h10] = 32'h3F800000; ram[16'h11] = 32'h40000000; ram[16'h12] = 32'h40400000;
        run_job(16'h0010, 16'd1, 0, 1'b0);
        chk("ident_last", {out_x, out_y, out_z, out_w},
            {32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000});

        // Scale-by-2 on x,y,z with w kept at 1.0.
        eng_e = '{1, 1, 1, 0};
        run_job(16'($urandom_range(0, 60000)), 16'd3, 0, 1'b0);

        run_job(16'($urandom_range(0, 60000)), 16'd2, 2, 1'b0);

        eng_e = '{$urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2)};
        run_job(16'($urandom), 16'd4, 1, 1'b0);

        // Zero-length job: immediate done, no reads, no engine start.
        saved     = mem_addr;
        cmd_base  = 16'h4444;
        cmd_count = 16'd0;
        cmd_start = 1'b1;
        @(negedge clock);
        cmd_start = 1'b0;
        chk("zero_done", 128'(job_done), 128'(1));
        chk("zero_busy", 128'(busy), 128'(0));
        chk("zero_start", 128'(mv_start), 128'(0));
        @(negedge clock);
        chk("zero_done_drop", 128'(job_done), 128'(0));
        chk("zero_addr", 128'(mem_addr), 128'(saved));
        chk("zero_start2", 128'(mv_start), 128'(0));

        // Reset while the engine is running abandons the job.
        cmd_base  = 16'($urandom);
        cmd_count = 16'd2;
        cmd_start = 1'b1;
        @(negedge clock);
        cmd_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clock);
            if (mv_start) seen = 1'b1;
        end
        chk("reached_start", 128'(seen), 128'(1));
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_valid", 128'(out_valid), 128'(0));
        chk("midrst_done", 128'(job_done), 128'(0));
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_done2", 128'(job_done), 128'(0));
        run_job(16'($urandom), 16'd1, 1, 1'b0);

        // Address wrap, with a stray command mid-job.
        run_job(16'hFFFE, 16'd2, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
